// File: rtl/loader_pkg.sv
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the imem loader slice.
//               LOADER_CHECKSUM_EN adds the CHK state to the FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    // Stream bytes and the trailing checksum byte share this width.
    localparam int CHK_W = 8;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHK   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/word_packer.sv
// ============================================================================
// Module      : word_packer
// Description : Assembles little-endian words from a byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_packer
    import loader_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            push,
    input  logic [CHK_W-1:0]                byte_in,
    output logic                            word_valid,
    output logic [BYTES_PER_WORD*CHK_W-1:0] word
);

    localparam int                CNT_W     = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
    localparam int                PART_W    = (BYTES_PER_WORD - 1) * CHK_W;

    logic [CNT_W-1:0]  byte_cnt;
    logic [PART_W-1:0] partial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            partial  <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            partial  <= '0;
        end else if (push) begin
            // Counter wraps naturally after the last byte of a word.
            byte_cnt <= byte_cnt + CNT_W'(1);
            partial  <= {byte_in, partial[PART_W-1:CHK_W]};
        end
    end

    // The final byte is merged combinationally so the word is ready on its push.
    assign word_valid = push && (byte_cnt == LAST_BYTE);
    assign word       = {byte_in, partial};

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Fills instruction memory from a host byte stream and holds
//               the CPU in reset until the load completes.
//               Optional trailing checksum byte: LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len_words,
    input  logic [CHK_W-1:0]  s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t              state;
    logic [ADDR_W:0]     len;
    logic [ADDR_W:0]     word_cnt;
    logic                start_ok;
    logic                push;
    logic                word_valid;
    logic [WORD_W-1:0]   word;
    logic                last_word;

    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign push      = s_valid && s_ready && (state == ST_RECV);
    assign last_word = (word_cnt + (ADDR_W+1)'(1)) == len;

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .push       (push),
        .byte_in    (s_data),
        .word_valid (word_valid),
        .word       (word)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [CHK_W-1:0] sum;
    logic [CHK_W-1:0] chk_total;

    assign chk_total = sum + s_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            len        <= '0;
            word_cnt   <= '0;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst_n  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        len       <= len_words;
                        word_cnt  <= '0;
                        err       <= 1'b0;
                        cpu_rst_n <= 1'b0;
                        done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum       <= '0;
`endif
                        if (len_words > MAX_LEN) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else if (len_words == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            // Empty load still has to present a zero checksum.
                            state   <= ST_CHK;
                            s_ready <= 1'b1;
                            busy    <= 1'b1;
`else
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
`endif
                        end else begin
                            state   <= ST_RECV;
                            s_ready <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end

                ST_RECV: begin
`ifdef LOADER_CHECKSUM_EN
                    if (push) begin
                        sum <= sum + s_data;
                    end
`endif
                    if (word_valid) begin
                        state      <= ST_WRITE;
                        s_ready    <= 1'b0;
                        imem_we    <= 1'b1;
                        imem_addr  <= word_cnt[ADDR_W-1:0];
                        imem_wdata <= word;
                    end
                end

                ST_WRITE: begin
                    imem_we  <= 1'b0;
                    word_cnt <= word_cnt + (ADDR_W+1)'(1);
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state   <= ST_CHK;
                        s_ready <= 1'b1;
`else
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_rst_n <= !err;
`endif
                    end else begin
                        state   <= ST_RECV;
                        s_ready <= 1'b1;
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (s_valid) begin
                        state     <= ST_DONE;
                        s_ready   <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        err       <= (chk_total != '0);
                        cpu_rst_n <= (chk_total == '0);
                    end
                end
`endif

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader with a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2**ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len_words = '0;
    logic [7:0]        s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W), .WORD_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len_words  (len_words),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    int          nwrites = 0;
    int          bytes_left = 0;
    bit          we_due = 1'b0;
    wr_t         exp_q[$];
    logic [31:0] dut_mem [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every data byte accepted is counted; each fourth one must produce a
    // write on the following cycle, matching the next queued model word.
    always @(negedge clk) begin
        if (!rst_n) begin
            we_due = 1'b0;
        end else begin
            chk("imem_we_timing", 32'(imem_we), 32'(we_due));
            if (imem_we) begin
                nwrites++;
                dut_mem[imem_addr] = imem_wdata;
                chk("s_ready_in_write", 32'(s_ready), 32'd0);
                chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("imem_addr", 32'(imem_addr), 32'(e.addr));
                    chk("imem_wdata", imem_wdata, e.data);
                end
            end
            if (s_ready) chk("busy_while_ready", 32'(busy), 32'd1);
            we_due = 1'b0;
            if (s_valid && s_ready && bytes_left > 0) begin
                bytes_left--;
                if (bytes_left % 4 == 0) we_due = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_s_ready"},    32'(s_ready),   32'd0);
        chk({tag, "_imem_we"},    32'(imem_we),   32'd0);
        chk({tag, "_imem_addr"},  32'(imem_addr), 32'd0);
        chk({tag, "_imem_wdata"}, imem_wdata,     32'd0);
        chk({tag, "_cpu_rst_n"},  32'(cpu_rst_n), 32'd0);
        chk({tag, "_busy"},       32'(busy),      32'd0);
        chk({tag, "_done"},       32'(done),      32'd0);
        chk({tag, "_err"},        32'(err),       32'd0);
    endtask

    task automatic model_words(input int L, input logic [7:0] b[$]);
        for (int i = 0; i < L; i++) begin
            wr_t w;
            w.addr = ADDR_W'(i);
            w.data = 32'(b[4*i]) + (32'(b[4*i+1]) << 8) + (32'(b[4*i+2]) << 16)
                   + (32'(b[4*i+3]) << 24);
            exp_q.push_back(w);
        end
    endtask

    task automatic do_start(input int L);
        bytes_left = (L >= 1 && L <= DEPTH) ? 4 * L : 0;
        start      = 1'b1;
        len_words  = (ADDR_W+1)'(L);
        tick();
        start      = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 3)) tick();
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) chk("s_ready_timeout", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic run_load(input string tag, input int L, input logic [7:0] b[$],
                            input bit gaps, input bit noise, input bit bad_chk);
        int w0;
        bit err_exp;
        w0      = nwrites;
        err_exp = 1'b0;
        model_words(L, b);
        do_start(L);
        chk({tag, "_busy_start"}, 32'(busy),      32'd1);
        chk({tag, "_done_start"}, 32'(done),      32'd0);
        chk({tag, "_cpu_start"},  32'(cpu_rst_n), 32'd0);
        if (noise) begin
            // A start pulse mid-load must not disturb the transfer.
            start     = 1'b1;
            len_words = '0;
            tick();
            start     = 1'b0;
        end
        foreach (b[i]) push_byte(b[i], gaps);
`ifdef LOADER_CHECKSUM_EN
        begin
            int         sum = 0;
            logic [7:0] cb;
            foreach (b[i]) sum += int'(b[i]);
            cb      = bad_chk ? 8'h00 : 8'((256 - (sum % 256)) % 256);
            err_exp = ((sum + int'(cb)) % 256) != 0;
            push_byte(cb, gaps);
        end
`else
        if (bad_chk) err_exp = 1'b0;
`endif
        wait_done(tag);
        chk({tag, "_err"},    32'(err),       32'(err_exp));
        chk({tag, "_cpu"},    32'(cpu_rst_n), 32'(!err_exp));
        chk({tag, "_busy"},   32'(busy),      32'd0);
        chk({tag, "_nwrite"}, 32'(nwrites - w0), 32'(L));
        chk({tag, "_queue"},  32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] q[$];
        int         w0;

        rst_n = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load("basic", 2, q, 1'b0, 1'b0, 1'b0);
        chk("basic_mem0", dut_mem[0], 32'h12345678);
        chk("basic_mem1", dut_mem[1], 32'hDEADBEEF);

        dut_mem[0] = '0;
        dut_mem[1] = '0;
        run_load("gaps", 2, q, 1'b1, 1'b1, 1'b0);
        chk("gaps_mem0", dut_mem[0], 32'h12345678);
        chk("gaps_mem1", dut_mem[1], 32'hDEADBEEF);

        w0 = nwrites;
        do_start(0);
`ifdef LOADER_CHECKSUM_EN
        chk("len0_busy",  32'(busy),    32'd1);
        chk("len0_ready", 32'(s_ready), 32'd1);
        push_byte(8'h00, 1'b0);
        wait_done("len0");
`else
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
`endif
        chk("len0_err", 32'(err),       32'd0);
        chk("len0_cpu", 32'(cpu_rst_n), 32'd1);
        repeat (3) tick();
        chk("len0_nwrite", 32'(nwrites - w0), 32'd0);

        w0 = nwrites;
        do_start(DEPTH + 1);
        chk("len257_done", 32'(done),      32'd1);
        chk("len257_err",  32'(err),       32'd1);
        chk("len257_cpu",  32'(cpu_rst_n), 32'd0);
        repeat (3) tick();
        chk("len257_cpu_hold", 32'(cpu_rst_n), 32'd0);
        chk("len257_nwrite",   32'(nwrites - w0), 32'd0);

        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        model_words(2, q);
        do_start(2);
        for (int i = 0; i < 6; i++) push_byte(q[i], 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        bytes_left = 0;
        #1;
        check_reset_values("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load("after_rst", 1, q, 1'b0, 1'b0, 1'b0);
        chk("after_rst_mem0", dut_mem[0], 32'hDDCCBBAA);

`ifdef LOADER_CHECKSUM_EN
        q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load("chk_good", 1, q, 1'b0, 1'b0, 1'b0);
        chk("chk_good_err_lit", 32'(err), 32'd0);
        run_load("chk_bad", 1, q, 1'b0, 1'b0, 1'b1);
        chk("chk_bad_err_lit", 32'(err),       32'd1);
        chk("chk_bad_cpu_lit", 32'(cpu_rst_n), 32'd0);
`endif

        for (int t = 0; t < 6; t++) begin
            int L;
            L = $urandom_range(1, 8);
            q.delete();
            for (int i = 0; i < 4 * L; i++) q.push_back(8'($urandom));
            run_load("rand", L, q, 1'b1, bit'($urandom_range(0, 1)), 1'b0);
        end

        q.delete();
        for (int i = 0; i < 4 * DEPTH; i++) q.push_back(8'($urandom));
        run_load("full", DEPTH, q, 1'b0, 1'b0, 1'b0);
        chk("full_last_word", dut_mem[DEPTH-1],
            32'(q[4*DEPTH-4]) | (32'(q[4*DEPTH-3]) << 8) |
            (32'(q[4*DEPTH-2]) << 16) | (32'(q[4*DEPTH-1]) << 24));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
